// File: rtl/exec_wb_pip3.sv
// Three-stage execute/writeback pipe: two-candidate issue arbiter, E1 operand latch, E2 ALU,
// E3 broadcast register. Optional multiply on uops 001_100 when EXEC_MUL_EN is defined.
module exec_wb_pip3 #(
  parameter int unsigned W_PD_UOPS  = 6,
  parameter int unsigned W_PD_DATA  = 32,
  parameter int unsigned W_PA_REG   = 5,
  parameter int unsigned W_AA_INSTR = 32,
  parameter logic [W_PD_UOPS-1:0] unused_op = {W_PD_UOPS{1'b1}}
) (
  input  logic                  clk,
  input  logic                  CFI_PC_rstn,
  input  logic [W_PD_UOPS-1:0]  CDI_PD_uops1,
  input  logic [W_PD_UOPS-1:0]  CDI_PD_uops2,
  input  logic [W_PA_REG-1:0]   CDI_PA_r1,
  input  logic [W_PA_REG-1:0]   CDI_PA_r2,
  input  logic                  CDI_PD_odr,
  input  logic [W_PD_UOPS-1:0]  DFI_PD_uops,
  input  logic [W_PD_DATA-1:0]  DFI_PD_rs,
  input  logic [W_PD_DATA-1:0]  DFI_PD_rt,
  input  logic [W_PD_DATA-1:0]  DFI_PD_imm,
  input  logic [W_AA_INSTR-1:0] DFI_AA_pc,
  input  logic                  CFI_PC_stall,
  input  logic                  CFI_PC_clear,
  output logic [1:0]            CDO_PC_s1,
  output logic [W_PD_DATA-1:0]  CDO_PD_upt1,
  output logic [W_PA_REG-1:0]   CDO_PA_upt1,
  output logic                  CDO_PV_upt1,
  output logic                  CFO_PC_busy
);

  logic                  e1_valid_q, e2_valid_q, e3_valid_q;
  logic [W_PD_UOPS-1:0]  e1_uops_q;
  logic [W_PD_DATA-1:0]  e1_rs_q, e1_rt_q, e1_imm_q;
  logic [W_AA_INSTR-1:0] e1_pc_q;
  logic [W_PA_REG-1:0]   e1_rd_q, e2_rd_q, e3_rd_q;
  logic [W_PD_DATA-1:0]  e2_res_q, e3_res_q;

  logic [1:0]           grant;
  logic                 cand0, cand1;
  logic [W_PD_DATA-1:0] alu_b, alu_res, pc_ext;
  logic                 alu_legal;

  // Reset gates the grant so no stray issue is visible while held in reset.
  always_comb begin
    grant = 2'b00;
    cand0 = (CDI_PD_uops1 != unused_op);
    cand1 = (CDI_PD_uops2 != unused_op);
    if (CFI_PC_rstn && !CFI_PC_clear && !CFI_PC_stall) begin
      if (cand0 && cand1) grant = CDI_PD_odr ? 2'b10 : 2'b01;
      else if (cand0)     grant = 2'b01;
      else if (cand1)     grant = 2'b10;
    end
  end

  assign CDO_PC_s1 = grant;

  always_comb begin
    alu_res   = '0;
    alu_legal = 1'b0;
    pc_ext    = W_PD_DATA'(e1_pc_q);
    alu_b     = (e1_uops_q[5:3] == 3'b010) ? e1_imm_q : e1_rt_q;
    case (e1_uops_q[5:3])
      3'b001, 3'b010: begin
        alu_legal = 1'b1;
        case (e1_uops_q[2:0])
          3'b000:  alu_res = e1_rs_q + alu_b;
          3'b001:  alu_res = e1_rs_q - alu_b;
          3'b010:  alu_res = e1_rs_q & alu_b;
          3'b011:  alu_res = e1_rs_q | alu_b;
`ifdef EXEC_MUL_EN
          3'b100: begin
            alu_res   = e1_rs_q * e1_rt_q;
            alu_legal = (e1_uops_q[5:3] == 3'b001);
          end
`endif
          default: alu_legal = 1'b0;
        endcase
      end
      3'b011: begin
        alu_legal = (e1_uops_q[2:0] == 3'b000);
        alu_res   = pc_ext + e1_imm_q;
      end
      default: alu_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge CFI_PC_rstn) begin
    if (!CFI_PC_rstn) begin
      e1_valid_q <= 1'b0;
      e2_valid_q <= 1'b0;
      e3_valid_q <= 1'b0;
      e1_uops_q  <= '0;
      e1_rs_q    <= '0;
      e1_rt_q    <= '0;
      e1_imm_q   <= '0;
      e1_pc_q    <= '0;
      e1_rd_q    <= '0;
      e2_rd_q    <= '0;
      e2_res_q   <= '0;
      e3_rd_q    <= '0;
      e3_res_q   <= '0;
    end else if (CFI_PC_clear) begin
      e1_valid_q <= 1'b0;
      e2_valid_q <= 1'b0;
      e3_valid_q <= 1'b0;
    end else if (!CFI_PC_stall) begin
      e1_valid_q <= |grant;
      if (|grant) begin
        e1_uops_q <= DFI_PD_uops;
        e1_rs_q   <= DFI_PD_rs;
        e1_rt_q   <= DFI_PD_rt;
        e1_imm_q  <= DFI_PD_imm;
        e1_pc_q   <= DFI_AA_pc;
        e1_rd_q   <= grant[1] ? CDI_PA_r2 : CDI_PA_r1;
      end
      // Illegal ops keep flowing but lose their valid bit here.
      e2_valid_q <= e1_valid_q && alu_legal;
      e2_res_q   <= alu_res;
      e2_rd_q    <= e1_rd_q;
      // Writes to r0 never broadcast.
      e3_valid_q <= e2_valid_q && (e2_rd_q != '0);
      e3_res_q   <= e2_res_q;
      e3_rd_q    <= e2_rd_q;
    end
  end

  assign CDO_PV_upt1 = e3_valid_q;
  assign CDO_PD_upt1 = e3_res_q;
  assign CDO_PA_upt1 = e3_rd_q;
  assign CFO_PC_busy = e1_valid_q | e2_valid_q | e3_valid_q;

endmodule

// File: tb/tb_exec_wb_pip3.sv
// Scoreboard bench for exec_wb_pip3: driver pushes expected broadcasts tagged with the advancing
// edge count at which they must appear; a negedge monitor pops and compares.
module tb_exec_wb_pip3;

  localparam logic [5:0] UN = 6'o77;

  logic        clk, rstn;
  logic [5:0]  uops1, uops2, duops;
  logic [4:0]  r1, r2;
  logic        odr, stall, clear;
  logic [31:0] rs, rt, imm, pc;
  logic [1:0]  s1;
  logic [31:0] pd;
  logic [4:0]  pa;
  logic        pv, busy;

  exec_wb_pip3 dut (
    .clk          (clk),
    .CFI_PC_rstn  (rstn),
    .CDI_PD_uops1 (uops1),
    .CDI_PD_uops2 (uops2),
    .CDI_PA_r1    (r1),
    .CDI_PA_r2    (r2),
    .CDI_PD_odr   (odr),
    .DFI_PD_uops  (duops),
    .DFI_PD_rs    (rs),
    .DFI_PD_rt    (rt),
    .DFI_PD_imm   (imm),
    .DFI_AA_pc    (pc),
    .CFI_PC_stall (stall),
    .CFI_PC_clear (clear),
    .CDO_PC_s1    (s1),
    .CDO_PD_upt1  (pd),
    .CDO_PA_upt1  (pa),
    .CDO_PV_upt1  (pv),
    .CFO_PC_busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    int          target;
  } exp_t;

  exp_t       sb[$];
  int         adv_cnt = 0;
  logic [1:0] exp_grant = 2'b00;
  int         n_total = 0;
  int         n_pass = 0;

  task automatic check(input string name, input bit ok, input logic [63:0] act,
                       input logic [63:0] req);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
  endtask

  // Reference: result of one uop from plain arithmetic; returns 0 when no result is produced.
  function automatic bit model(input logic [5:0] u, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] i, input logic [31:0] p,
                               output logic [31:0] r);
    bit ok = 1'b1;
    r = 32'h0;
    case (u)
      6'o10: r = a + b;
      6'o11: r = a - b;
      6'o12: r = a & b;
      6'o13: r = a | b;
      6'o20: r = a + i;
      6'o21: r = a - i;
      6'o22: r = a & i;
      6'o23: r = a | i;
      6'o30: r = p + i;
`ifdef EXEC_MUL_EN
      6'o14: r = 32'((64'(a) * 64'(b)) % 64'h1_0000_0000);
`endif
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  always @(posedge clk) if (rstn && !stall) adv_cnt <= adv_cnt + 1;

  // Monitor
  always @(negedge clk) begin
    check("grant", s1 === exp_grant, 64'(s1), 64'(exp_grant));
    if (rstn) begin
      if (sb.size() != 0)
        check("result_not_lost", sb[0].target >= adv_cnt, 64'(sb[0].target), 64'(adv_cnt));
      while (sb.size() != 0 && sb[0].target < adv_cnt) void'(sb.pop_front());
      if (sb.size() != 0 && sb[0].target == adv_cnt) begin
        check("bcast_valid", pv === 1'b1, 64'(pv), 64'd1);
        check("bcast_rd", pa === sb[0].rd, 64'(pa), 64'(sb[0].rd));
        check("bcast_data", pd === sb[0].data, 64'(pd), 64'(sb[0].data));
        if (!stall) void'(sb.pop_front());
      end else begin
        check("no_bcast", pv === 1'b0, 64'(pv), 64'd0);
      end
    end
  end

  // One cycle of stimulus: drive, derive expectation, push, advance to posedge+1.
  task automatic issue(input logic [5:0] u1, input logic [5:0] u2, input logic [4:0] a1,
                       input logic [4:0] a2, input logic o, input logic [5:0] du,
                       input logic [31:0] vrs, input logic [31:0] vrt, input logic [31:0] vimm,
                       input logic [31:0] vpc, input logic st, input logic cl);
    logic [31:0] r;
    logic [4:0]  rd;
    bit          p0, p1, ok;
    uops1 = u1; uops2 = u2; r1 = a1; r2 = a2; odr = o; duops = du;
    rs = vrs; rt = vrt; imm = vimm; pc = vpc; stall = st; clear = cl;
    p0 = (u1 != UN);
    p1 = (u2 != UN);
    if (st || cl || !(p0 || p1)) exp_grant = 2'b00;
    else if (p0 && p1)           exp_grant = o ? 2'b10 : 2'b01;
    else                         exp_grant = p0 ? 2'b01 : 2'b10;
    if (exp_grant != 2'b00) begin
      rd = (exp_grant == 2'b10) ? a2 : a1;
      ok = model(du, vrs, vrt, vimm, vpc, r);
      if (ok && rd != 5'd0) sb.push_back('{rd: rd, data: r, target: adv_cnt + 3});
    end
    @(posedge clk);
    #1;
    if (cl) sb.delete();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) issue(UN, UN, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_s1"}, s1 === 2'b00, 64'(s1), 64'd0);
    check({tag, "_pv"}, pv === 1'b0, 64'(pv), 64'd0);
    check({tag, "_pd"}, pd === 32'h0, 64'(pd), 64'd0);
    check({tag, "_pa"}, pa === 5'h0, 64'(pa), 64'd0);
    check({tag, "_busy"}, busy === 1'b0, 64'(busy), 64'd0);
  endtask

  logic [5:0] ops [10] = '{6'o10, 6'o11, 6'o12, 6'o13, 6'o20, 6'o21, 6'o22, 6'o23, 6'o30, 6'o14};

  function automatic logic [5:0] rnd_op();
    if ($urandom_range(0, 7) == 0) return 6'($urandom_range(0, 62));
    return ops[$urandom_range(0, 9)];
  endfunction

  initial begin
    rstn = 1'b0; stall = 1'b0; clear = 1'b0; odr = 1'b0;
    uops1 = UN; uops2 = UN; duops = 6'h0; r1 = 5'h0; r2 = 5'h0;
    rs = 32'h0; rt = 32'h0; imm = 32'h0; pc = 32'h0;
    #3;
    check_all_zero("reset");
    @(posedge clk); @(posedge clk); #1;
    rstn = 1'b1;

    // 5 - 3 to r7, candidate 0 only.
    issue(6'o11, UN, 5'd7, 5'd0, 1'b0, 6'o11, 32'd5, 32'd3, 0, 0, 1'b0, 1'b0);
    idle(4);
    // Arbitration by age, and no candidates.
    issue(6'o10, 6'o10, 5'd1, 5'd2, 1'b1, 6'o10, 32'd10, 32'd20, 0, 0, 1'b0, 1'b0);
    issue(6'o10, 6'o10, 5'd1, 5'd2, 1'b0, 6'o10, 32'd11, 32'd22, 0, 0, 1'b0, 1'b0);
    issue(UN, UN, 5'd1, 5'd2, 1'b0, 6'o10, 32'd1, 32'd1, 0, 0, 1'b0, 1'b0);
    idle(4);
    // Wrap-around add-immediate, then the same op to r0.
    issue(6'o20, UN, 5'd3, 5'd0, 1'b0, 6'o20, 32'hFFFF_FFFF, 0, 32'd1, 0, 1'b0, 1'b0);
    issue(6'o20, UN, 5'd0, 5'd0, 1'b0, 6'o20, 32'hFFFF_FFFF, 0, 32'd1, 0, 1'b0, 1'b0);
    idle(4);
    // Back-to-back adds with a 2-cycle stall while the first sits on the outputs.
    issue(6'o10, UN, 5'd4, 5'd0, 1'b0, 6'o10, 32'd1, 32'd1, 0, 0, 1'b0, 1'b0);
    issue(6'o10, UN, 5'd5, 5'd0, 1'b0, 6'o10, 32'd2, 32'd2, 0, 0, 1'b0, 1'b0);
    issue(6'o10, UN, 5'd6, 5'd0, 1'b0, 6'o10, 32'd3, 32'd3, 0, 0, 1'b0, 1'b0);
    issue(6'o10, UN, 5'd8, 5'd0, 1'b0, 6'o10, 32'd4, 32'd4, 0, 0, 1'b1, 1'b0);
    issue(6'o10, UN, 5'd8, 5'd0, 1'b0, 6'o10, 32'd4, 32'd4, 0, 0, 1'b1, 1'b0);
    issue(6'o10, UN, 5'd8, 5'd0, 1'b0, 6'o10, 32'd4, 32'd4, 0, 0, 1'b0, 1'b0);
    idle(5);
    // Clear beats stall with three ops in flight.
    for (int k = 0; k < 3; k++)
      issue(6'o13, UN, 5'(k + 10), 5'd0, 1'b0, 6'o13, 32'(k), 32'h100, 0, 0, 1'b0, 1'b0);
    issue(6'o13, UN, 5'd9, 5'd0, 1'b0, 6'o13, 32'd1, 32'd2, 0, 0, 1'b1, 1'b1);
    check("clear_busy", busy === 1'b0, 64'(busy), 64'd0);
    check("clear_pv", pv === 1'b0, 64'(pv), 64'd0);
    idle(2);
    // Asynchronous reset mid-stream with candidates still requesting.
    issue(6'o30, UN, 5'd12, 5'd0, 1'b0, 6'o30, 0, 0, 32'd8, 32'h1000, 1'b0, 1'b0);
    issue(6'o30, UN, 5'd13, 5'd0, 1'b0, 6'o30, 0, 0, 32'd4, 32'h2000, 1'b0, 1'b0);
    issue(6'o30, 6'o10, 5'd14, 5'd15, 1'b0, 6'o30, 0, 0, 32'd4, 32'h3000, 1'b0, 1'b0);
    #2 rstn = 1'b0;
    exp_grant = 2'b00;
    #1 check_all_zero("midreset");
    sb.delete();
    @(posedge clk); #1;
    rstn = 1'b1;
    idle(1);
    // Multiply: 42 when enabled, otherwise illegal.
    issue(6'o14, UN, 5'd9, 5'd0, 1'b0, 6'o14, 32'd6, 32'd7, 0, 0, 1'b0, 1'b0);
    idle(4);

    for (int n = 0; n < 400; n++) begin
      logic [5:0] a, b;
      a = ($urandom_range(0, 9) < 7) ? rnd_op() : UN;
      b = ($urandom_range(0, 9) < 5) ? rnd_op() : UN;
      issue(a, b, ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom),
            ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom), 1'($urandom), rnd_op(),
            $urandom, $urandom, $urandom, $urandom,
            $urandom_range(0, 9) == 0, $urandom_range(0, 29) == 0);
    end
    idle(6);
    check("drained", sb.size() == 0, 64'(sb.size()), 64'd0);
    check("idle_busy", busy === 1'b0, 64'(busy), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/exec_wb_pip3.md
EXEC_WB_PIP3 -- requirements
Module: exec_wb_pip3

Interface
REQ-001 SHALL have parameters (name, default, meaning): W_PD_UOPS, 6, micro-op width.
REQ-002 SHALL have parameter W_PD_DATA, 32, operand/result width.
REQ-003 SHALL have parameter W_PA_REG, 5, register address width.
REQ-004 SHALL have parameter W_AA_INSTR, 32, pc width.
REQ-005 SHALL have parameter unused_op, all-ones of W_PD_UOPS, marks "no candidate".
REQ-006 SHALL have ports (name, direction, width, meaning), clock and reset first:
- clk  in  1  single clock, rising edge.
- CFI_PC_rstn  in  1  reset, asynchronous, active-low.
- CDI_PD_uops1  in  W_PD_UOPS  candidate-0 uops; unused_op means none.
- CDI_PD_uops2  in  W_PD_UOPS  candidate-1 uops; unused_op means none.
- CDI_PA_r1  in  W_PA_REG  candidate-0 rd.
- CDI_PA_r2  in  W_PA_REG  candidate-1 rd.
- CDI_PD_odr  in  1  1 = candidate-1 older.
- DFI_PD_uops, DFI_PD_rs, DFI_PD_rt, DFI_PD_imm  in  W_PD_UOPS/W_PD_DATA x3  operands of the granted entry, valid in the grant cycle.
- DFI_AA_pc  in  W_AA_INSTR  pc of the granted entry.
- CFI_PC_stall  in  1  writeback consumer cannot accept; freeze.
- CFI_PC_clear  in  1  synchronous flush.
- CDO_PC_s1  out  2  one-hot issue grant: bit0 = candidate 0, bit1 = candidate 1.
- CDO_PD_upt1  out  W_PD_DATA  broadcast result.
- CDO_PA_upt1  out  W_PA_REG  broadcast rd.
- CDO_PV_upt1  out  1  broadcast valid.
- CFO_PC_busy  out  1  any pipeline stage valid.

Function
REQ-007 SHALL compute CDO_PC_s1 combinationally: 0 if CFI_PC_clear or CFI_PC_stall; otherwise, if both candidates are present, grant the older per CDI_PD_odr; if only one is present, grant it; if none, 0.
REQ-008 SHALL never assert both CDO_PC_s1 bits.
REQ-009 SHALL capture DFI_* and the granted rd into stage E1 on the edge that ends the grant cycle, with E1.valid=1.
REQ-010 SHALL advance E1->E2 (ALU) -> E3 (output register) one stage per cycle when not stalled; the result is visible on CDO_* in the 3rd cycle after the grant cycle (latency 3).
REQ-011 SHALL decode uops as follows:
- [5:3]=001, [2:0]=0/1/2/3: rs ADD/SUB/AND/OR rt.
- [5:3]=010, same [2:0]: the same operation with imm in place of rt.
- [5:3]=011, [2:0]=0: pc+imm.
REQ-012 SHALL treat all other uops as illegal: carry the op through the pipeline with valid cleared, so no broadcast occurs.
REQ-013 SHALL truncate arithmetic to W_PD_DATA bits with wrap-around, ignoring carry and overflow.
REQ-014 SHALL suppress the broadcast (CDO_PV_upt1=0) when rd==0; CDO_PD_upt1 is then don't-care.
REQ-015 SHALL drive CDO_PV_upt1 = E3.valid, and SHALL drive CDO_PD_upt1 and CDO_PA_upt1 from the E3 register.
REQ-016 SHALL, while CFI_PC_stall=1, hold all stages and outputs unchanged and issue no grant; a held broadcast remains asserted until the stall drops.
REQ-017 SHALL, on CFI_PC_clear=1, clear all valid bits at the next edge and issue no grant in that cycle; clear has priority over stall.
REQ-018 SHALL drive CFO_PC_busy = E1.valid | E2.valid | E3.valid.
REQ-019 SHALL sustain one grant per cycle back-to-back when not stalled.

Reset
REQ-020 SHALL, while CFI_PC_rstn=0, asynchronously clear all valid bits and force CDO_PC_s1=0, CDO_PV_upt1=0, CDO_PD_upt1=0, CDO_PA_upt1=0, CFO_PC_busy=0.
REQ-021 SHALL discard any in-flight ops when reset asserts mid-operation; normal operation resumes on the first edge after deassertion.

Configuration
REQ-022 SHALL support macro EXEC_MUL_EN. When defined, uops 001_100 = low W_PD_DATA bits of rs*rt, computed in E2 with the same latency 3. When undefined, 001_100 is illegal per REQ-012.

Verification
REQ-023 SHALL cover: rs=5, rt=3, uops=001_001, rd=7, only candidate 0 present -> CDO_PC_s1=01; three cycles later CDO_PV_upt1=1, CDO_PA_upt1=7, CDO_PD_upt1=2.
REQ-024 SHALL cover: both candidates present, CDI_PD_odr=1 -> CDO_PC_s1=10; with odr=0 -> 01; with both uops=unused_op -> 00.
REQ-025 SHALL cover: uops=010_000, rs=0xFFFFFFFF, imm=1, rd=3 -> result 0x00000000 (wrap-around); the same op with rd=0 -> CDO_PV_upt1 stays 0.
REQ-026 SHALL cover: four back-to-back ADDs, CFI_PC_stall held for 2 cycles while the first is on the outputs -> broadcast held 2 cycles, no grants during the stall, all four results delivered in order with none lost.
REQ-027 SHALL cover: CFI_PC_clear and CFI_PC_stall both asserted with 3 ops in flight -> next cycle CFO_PC_busy=0 and no broadcast; CFI_PC_rstn pulsed low mid-stream -> all outputs 0 immediately.
REQ-028 SHALL cover: uops=001_100, rs=6, rt=7 -> with EXEC_MUL_EN, result 42 at latency 3; without it, no broadcast.
